// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with branch, jump and call/return.
// Optional return-address stack is built when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              OFF_W     = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pc_e,
  input  logic                         stall,
  input  logic                         j_flag,
  input  logic [PC_W-1:0]              j_addr,
  input  logic                         br_flag,
  input  logic [OFF_W-1:0]             br_off,
  input  logic                         call_flag,
  input  logic                         ret_flag,
  output logic [PC_W-1:0]              pc_out,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] off_sx;
  logic            upd;

  assign upd    = pc_e & ~stall;
  assign pc_inc = pc_q + 1'b1;
  assign j_tgt  = j_addr + 1'b1;
  assign off_sx = PC_W'($signed(br_off));
  assign br_tgt = pc_q + off_sx + 1'b1;
  assign pc_out = pc_q;

`ifdef PC_SEQ_RAS_EN

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push;
  logic [PC_W-1:0]  stk_q [RAS_DEPTH];

  // sp_q is the next write slot; top is the newest entry
  assign top       = sp_q - 1'b1;
  assign ras_cnt   = cnt_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FULL_CNT);
  assign ras_err   = err_q;

  // next-state: ret > call > jump > branch > increment
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (upd) begin
      if (ret_flag) begin
        if (cnt_q != '0) begin
          pc_d  = stk_q[top];
          sp_d  = top;
          cnt_d = cnt_q - 1'b1;
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (call_flag) begin
        push = 1'b1;
        pc_d = j_tgt;
        sp_d = sp_q + 1'b1;
        if (cnt_q == FULL_CNT) err_d = 1'b1;
        else                   cnt_d = cnt_q + 1'b1;
      end else if (j_flag) begin
        pc_d = j_tgt;
      end else if (br_flag) begin
        pc_d = br_tgt;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // PC and stack bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // stack storage; full stack overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (push && !rst) stk_q[sp_q] <= pc_inc;
  end

`else

  assign ras_cnt   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;

  // next PC: ret acts as increment, call acts as jump
  always_comb begin
    pc_d = pc_q;
    if (upd) begin
      if (ret_flag)                 pc_d = pc_inc;
      else if (call_flag || j_flag) pc_d = j_tgt;
      else if (br_flag)             pc_d = br_tgt;
      else                          pc_d = pc_inc;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VEC;
    else     pc_q <= pc_d;
  end

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queue-based scoreboard.
// Covers both PC_SEQ_RAS_EN builds.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, pc_e, stall;
  logic        j_flag, br_flag, call_flag, ret_flag;
  logic [15:0] j_addr;
  logic [7:0]  br_off;
  logic [15:0] pc_out;
  logic [2:0]  ras_cnt;
  logic        ras_empty, ras_full, ras_err;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        err;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W(16), .OFF_W(8), .RAS_DEPTH(4), .RESET_VEC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .pc_e(pc_e), .stall(stall),
    .j_flag(j_flag), .j_addr(j_addr),
    .br_flag(br_flag), .br_off(br_off),
    .call_flag(call_flag), .ret_flag(ret_flag),
    .pc_out(pc_out), .ras_cnt(ras_cnt),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor: every edge presents a new registered state
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.nm, ".pc"},    pc_out,           e.pc);
        chk({e.nm, ".cnt"},   {13'd0, ras_cnt}, {13'd0, e.cnt});
        chk({e.nm, ".empty"}, {15'd0, ras_empty},
            {15'd0, (e.cnt == 3'd0)});
        chk({e.nm, ".full"},  {15'd0, ras_full},
            {15'd0, (e.cnt == 3'd4)});
        chk({e.nm, ".err"},   {15'd0, ras_err}, {15'd0, e.err});
      end
    end
  end

  // kinds: I inc, S stall, N pc_e=0, J jump, B branch, C call,
  // R ret, X call+ret, Z reset, Y reset+call
  task automatic step(input byte k, input logic [15:0] a,
                      input logic [7:0] off, input logic [15:0] epc,
                      input logic [2:0] ecnt, input logic eerr,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = 0; pc_e = 1; stall = 0;
    j_flag = 0; br_flag = 0; call_flag = 0; ret_flag = 0;
    j_addr = a; br_off = off;
    case (k)
      "S": begin stall = 1; call_flag = 1; end
      "N": begin pc_e = 0; call_flag = 1; end
      "J": j_flag = 1;
      "B": br_flag = 1;
      "C": call_flag = 1;
      "R": ret_flag = 1;
      "X": begin call_flag = 1; ret_flag = 1; end
      "Z": begin rst = 1; pc_e = 0; stall = 1; end
      "Y": begin rst = 1; call_flag = 1; end
      default: ;
    endcase
    e.pc = epc; e.cnt = ecnt; e.err = eerr; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    rst = 1; pc_e = 0; stall = 0;
    j_flag = 0; br_flag = 0; call_flag = 0; ret_flag = 0;
    j_addr = '0; br_off = '0;

    step("Z", 16'h0, 8'h0, 16'h0000, 3'd0, 0, "reset");
    step("I", 16'h0, 8'h0, 16'h0001, 3'd0, 0, "inc1");
    step("I", 16'h0, 8'h0, 16'h0002, 3'd0, 0, "inc2");
    step("I", 16'h0, 8'h0, 16'h0003, 3'd0, 0, "inc3");
    step("S", 16'h0, 8'h0, 16'h0003, 3'd0, 0, "stall1");
    step("S", 16'h0, 8'h0, 16'h0003, 3'd0, 0, "stall2");
    step("N", 16'h0, 8'h0, 16'h0003, 3'd0, 0, "pce0a");
    step("N", 16'h0, 8'h0, 16'h0003, 3'd0, 0, "pce0b");
    step("J", 16'h000F, 8'h0, 16'h0010, 3'd0, 0, "jmp10");
    step("J", 16'h0100, 8'h0, 16'h0101, 3'd0, 0, "jmp100");
    step("B", 16'h0, 8'hFC, 16'h00FE, 3'd0, 0, "brneg4");
    step("B", 16'h0, 8'h10, 16'h010F, 3'd0, 0, "brpos16");
    step("J", 16'hFFFE, 8'h0, 16'hFFFF, 3'd0, 0, "jmpFFFE");
    step("I", 16'h0, 8'h0, 16'h0000, 3'd0, 0, "wrap");
    step("J", 16'h001F, 8'h0, 16'h0020, 3'd0, 0, "jmp20");

`ifdef PC_SEQ_RAS_EN
    step("C", 16'h0200, 8'h0, 16'h0201, 3'd1, 0, "call1");
    step("C", 16'h0300, 8'h0, 16'h0301, 3'd2, 0, "call2");
    step("R", 16'h0, 8'h0, 16'h0202, 3'd1, 0, "ret1");
    step("R", 16'h0, 8'h0, 16'h0021, 3'd0, 0, "ret2");
    step("R", 16'h0, 8'h0, 16'h0022, 3'd0, 1, "retunder");
    step("S", 16'h0700, 8'h0, 16'h0022, 3'd0, 1, "stallcall");
    step("I", 16'h0, 8'h0, 16'h0023, 3'd0, 1, "errsticky");
    step("Z", 16'h0, 8'h0, 16'h0000, 3'd0, 0, "reset2");
    step("C", 16'h0100, 8'h0, 16'h0101, 3'd1, 0, "c5a");
    step("C", 16'h0200, 8'h0, 16'h0201, 3'd2, 0, "c5b");
    step("C", 16'h0300, 8'h0, 16'h0301, 3'd3, 0, "c5c");
    step("C", 16'h0400, 8'h0, 16'h0401, 3'd4, 0, "c5d");
    step("C", 16'h0500, 8'h0, 16'h0501, 3'd4, 1, "c5over");
    step("R", 16'h0, 8'h0, 16'h0402, 3'd3, 1, "r5a");
    step("R", 16'h0, 8'h0, 16'h0302, 3'd2, 1, "r5b");
    step("R", 16'h0, 8'h0, 16'h0202, 3'd1, 1, "r5c");
    step("R", 16'h0, 8'h0, 16'h0102, 3'd0, 1, "r5d");
    step("R", 16'h0, 8'h0, 16'h0103, 3'd0, 1, "r5under");
    step("Z", 16'h0, 8'h0, 16'h0000, 3'd0, 0, "reset3");
    step("C", 16'h0040, 8'h0, 16'h0041, 3'd1, 0, "callone");
    step("X", 16'h0080, 8'h0, 16'h0001, 3'd0, 0, "callret");
    step("C", 16'h0600, 8'h0, 16'h0601, 3'd1, 0, "b2bcall");
    step("R", 16'h0, 8'h0, 16'h0002, 3'd0, 0, "b2bret");
    step("C", 16'h0900, 8'h0, 16'h0901, 3'd1, 0, "precall");
    step("Y", 16'h0A00, 8'h0, 16'h0000, 3'd0, 0, "rstcall");
    step("R", 16'h0, 8'h0, 16'h0001, 3'd0, 1, "postrst");
`else
    step("C", 16'h0200, 8'h0, 16'h0201, 3'd0, 0, "nrcall");
    step("R", 16'h0, 8'h0, 16'h0202, 3'd0, 0, "nrret");
    step("R", 16'h0, 8'h0, 16'h0203, 3'd0, 0, "nrret2");
    step("X", 16'h0300, 8'h0, 16'h0204, 3'd0, 0, "nrcallret");
    step("Y", 16'h0400, 8'h0, 16'h0000, 3'd0, 0, "nrrstcall");
`endif

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
